// File: rtl/cpu_pkg.sv
// Shared constants for the datapath and the microprogrammed control unit:
// control-word bit positions, flag positions, opcodes and internal op/state enums.
package cpu_pkg;

  localparam int C_MBR_LD_MEM = 3;
  localparam int C_IR_LD      = 4;
  localparam int C_MAR_LD_MBR = 5;
  localparam int C_PC_INC     = 6;
  localparam int C_BR_LD      = 7;
  localparam int C_ACC_CLR    = 8;
  localparam int C_ACC_ADD    = 9;
  localparam int C_MAR_LD_PC  = 10;
  localparam int C_MEM_WE     = 11;
  localparam int C_MBR_LD_ACC = 12;
  localparam int C_ACC_SUB    = 13;
  localparam int C_PC_LD_MBR  = 14;
  localparam int C_ACC_MUL    = 15;
  localparam int C_ACC_DIV    = 16;
  localparam int C_ACC_SHL    = 17;
  localparam int C_ACC_SHR    = 18;
  localparam int C_ACC_AND    = 19;
  localparam int C_ACC_OR     = 20;
  localparam int C_ACC_NOT    = 21;

  localparam int FLAG_SF = 0;
  localparam int FLAG_OF = 1;
  localparam int FLAG_CF = 2;
  localparam int FLAG_ZF = 3;

  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_SHIFTR = 8'h0D;
  localparam logic [7:0] OP_SHIFTL = 8'h0E;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_ZERO} div_state_e;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_CLR, ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV,
    ALU_SHL, ALU_SHR, ALU_AND, ALU_OR, ALU_NOT
  } alu_op_e;

  function automatic logic [3:0] pack_flags(input logic zf, input logic cf,
                                            input logic of, input logic sf);
    logic [3:0] f;
    f = '0;
    f[FLAG_ZF] = zf;
    f[FLAG_CF] = cf;
    f[FLAG_OF] = of;
    f[FLAG_SF] = sf;
    return f;
  endfunction

endpackage

// File: rtl/cpu_datapath_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, DW cycles per divide.
// A zero divisor skips iteration and reports all-ones with div0 for one cycle.
module seq_divider
  import cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic          div0,
  output logic [DW-1:0] quotient
);

  localparam int CW = $clog2(DW);

  div_state_e    state, state_nxt;
  logic [DW-1:0] rem_q, quo_q, dsr_q;
  logic [DW-1:0] rem_nxt, quo_nxt;
  logic [CW-1:0] cnt_q;
  logic [DW:0]   rem_sh, diff;

  // quo_q doubles as the dividend shift register; quotient bits enter at the bottom
  always_comb begin
    rem_sh = {rem_q, quo_q[DW-1]};
    diff   = rem_sh - {1'b0, dsr_q};
    if (!diff[DW]) begin
      rem_nxt = diff[DW-1:0];
      quo_nxt = {quo_q[DW-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[DW-1:0];
      quo_nxt = {quo_q[DW-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    div0      = 1'b0;
    quotient  = quo_nxt;
    case (state)
      DIV_IDLE: if (start) state_nxt = (divisor == '0) ? DIV_ZERO : DIV_RUN;
      DIV_RUN: begin
        busy = 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          done      = 1'b1;
          state_nxt = DIV_IDLE;
        end
      end
      DIV_ZERO: begin
        busy      = 1'b1;
        done      = 1'b1;
        div0      = 1'b1;
        quotient  = '1;
        state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == DIV_IDLE && start) begin
        rem_q <= '0;
        quo_q <= dividend;
        dsr_q <= divisor;
        cnt_q <= '0;
      end else if (state == DIV_RUN) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// Register-transfer datapath driven by the CU control word: PC/MAR/MBR/IR/BR/ACC,
// the ALU with registered flags, and the iterative divider.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DW  = 16,
  parameter int OPW = 8,
  parameter int AW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ctrl,
  input  logic [DW-1:0]   mem_rdata,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_rd,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  output logic [OPW-1:0]  ir_out,
  output logic [3:0]      alu_flags,
  output logic [DW-1:0]   acc_out,
  output logic [AW-1:0]   pc_out,
  output logic            busy,
  output logic            ctl_err
);

  localparam int SW = $clog2(DW);

  logic [AW-1:0]   pc, mar;
  logic [DW-1:0]   mbr, br, acc;
  logic [OPW-1:0]  ir;
  logic [3:0]      flags;
  logic            err_q;

  logic [9:0]      alu_vec;
  logic            alu_any, alu_multi, err_now;
  alu_op_e         alu_op;
  logic [DW-1:0]   alu_res;
  logic            alu_cf, alu_of, alu_we;
  logic [DW:0]     sum_ext, dif_ext, shl_ext, shr_ext;
  logic [2*DW-1:0] prod;
  logic            shift_big;

  logic            div_start, div_done, div_zero;
  logic [DW-1:0]   div_q;
  logic            unused_ctrl;

  assign unused_ctrl = ^{ctrl[31:22], ctrl[2:0]};

  assign mem_addr  = mar;
  assign mem_rd    = ctrl[C_MBR_LD_MEM];
  assign mem_we    = ctrl[C_MEM_WE] & ~busy;
  assign mem_wdata = mbr;
  assign ir_out    = ir;
  assign alu_flags = flags;
  assign acc_out   = acc;
  assign pc_out    = pc;
  assign ctl_err   = err_q;

  assign alu_vec = {ctrl[C_ACC_NOT], ctrl[C_ACC_OR], ctrl[C_ACC_AND], ctrl[C_ACC_SHR],
                    ctrl[C_ACC_SHL], ctrl[C_ACC_DIV], ctrl[C_ACC_MUL], ctrl[C_ACC_SUB],
                    ctrl[C_ACC_ADD], ctrl[C_ACC_CLR]};
  assign alu_any   = |alu_vec;
  assign alu_multi = |(alu_vec & (alu_vec - 10'd1));

  assign err_now = (ctrl[C_MBR_LD_MEM] & ctrl[C_MBR_LD_ACC])
                 | (ctrl[C_MAR_LD_MBR] & ctrl[C_MAR_LD_PC])
                 | (ctrl[C_PC_INC] & ctrl[C_PC_LD_MBR])
                 | alu_multi
                 | (busy & (alu_any | ctrl[C_MEM_WE]));

  // The lowest set ALU bit selects the op; the whole group is frozen while dividing
  always_comb begin
    alu_op = ALU_NONE;
    if (!busy) begin
      if      (ctrl[C_ACC_CLR]) alu_op = ALU_CLR;
      else if (ctrl[C_ACC_ADD]) alu_op = ALU_ADD;
      else if (ctrl[C_ACC_SUB]) alu_op = ALU_SUB;
      else if (ctrl[C_ACC_MUL]) alu_op = ALU_MUL;
      else if (ctrl[C_ACC_DIV]) alu_op = ALU_DIV;
      else if (ctrl[C_ACC_SHL]) alu_op = ALU_SHL;
      else if (ctrl[C_ACC_SHR]) alu_op = ALU_SHR;
      else if (ctrl[C_ACC_AND]) alu_op = ALU_AND;
      else if (ctrl[C_ACC_OR])  alu_op = ALU_OR;
      else if (ctrl[C_ACC_NOT]) alu_op = ALU_NOT;
    end
  end

  assign div_start = (alu_op == ALU_DIV);

  // The extra top/bottom bit of each shift catches the last bit shifted out
  assign sum_ext   = {1'b0, acc} + {1'b0, br};
  assign dif_ext   = {1'b0, acc} - {1'b0, br};
  assign prod      = acc * br;
  assign shift_big = |br[DW-1:SW];
  assign shl_ext   = {1'b0, acc} << br[SW-1:0];
  assign shr_ext   = {acc, 1'b0} >> br[SW-1:0];

  always_comb begin
    alu_res = acc;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    alu_we  = 1'b1;
    case (alu_op)
      ALU_CLR: alu_res = '0;
      ALU_ADD: begin
        alu_res = sum_ext[DW-1:0];
        alu_cf  = sum_ext[DW];
        alu_of  = (acc[DW-1] == br[DW-1]) && (sum_ext[DW-1] != acc[DW-1]);
      end
      ALU_SUB: begin
        alu_res = dif_ext[DW-1:0];
        alu_cf  = dif_ext[DW];
        alu_of  = (acc[DW-1] != br[DW-1]) && (dif_ext[DW-1] != acc[DW-1]);
      end
      ALU_MUL: begin
        alu_res = prod[DW-1:0];
        alu_cf  = |prod[2*DW-1:DW];
        alu_of  = |prod[2*DW-1:DW];
      end
      ALU_SHL: begin
        alu_res = shift_big ? '0 : shl_ext[DW-1:0];
        alu_cf  = shift_big ? 1'b0 : shl_ext[DW];
      end
      ALU_SHR: begin
        alu_res = shift_big ? '0 : shr_ext[DW:1];
        alu_cf  = shift_big ? 1'b0 : shr_ext[0];
      end
      ALU_AND: alu_res = acc & br;
      ALU_OR:  alu_res = acc | br;
      ALU_NOT: alu_res = ~br;
      default: alu_we  = 1'b0;
    endcase
  end

  seq_divider #(.DW(DW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc),
    .divisor  (br),
    .busy     (busy),
    .done     (div_done),
    .div0     (div_zero),
    .quotient (div_q)
  );

  // Priority within each target register resolves the conflicting-transfer cases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      mar   <= '0;
      mbr   <= '0;
      ir    <= '0;
      br    <= '0;
      err_q <= 1'b0;
    end else begin
      if (ctrl[C_MBR_LD_MEM])      mbr <= mem_rdata;
      else if (ctrl[C_MBR_LD_ACC]) mbr <= acc;
      if (ctrl[C_IR_LD])           ir  <= mbr[DW-1:DW-OPW];
      if (ctrl[C_MAR_LD_PC])       mar <= pc;
      else if (ctrl[C_MAR_LD_MBR]) mar <= mbr[AW-1:0];
      if (ctrl[C_PC_LD_MBR])       pc  <= mbr[AW-1:0];
      else if (ctrl[C_PC_INC])     pc  <= pc + AW'(1);
      if (ctrl[C_BR_LD])           br  <= mbr;
      err_q <= err_q | err_now;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      flags <= '0;
    end else if (div_done) begin
      acc   <= div_q;
      flags <= pack_flags(div_q == '0, 1'b0, div_zero, div_q[DW-1]);
    end else if (alu_we) begin
      acc   <= alu_res;
      flags <= pack_flags(alu_res == '0, alu_cf, alu_of, alu_res[DW-1]);
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: the driver pushes hand-computed expectations,
// a monitor pops and compares them one clock later, after each rising edge.
module tb_cpu_datapath;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ctrl = '0;
  logic [15:0] mem_rdata;
  logic [7:0]  mem_addr;
  logic        mem_rd, mem_we;
  logic [15:0] mem_wdata;
  logic [7:0]  ir_out;
  logic [3:0]  alu_flags;
  logic [15:0] acc_out;
  logic [7:0]  pc_out;
  logic        busy, ctl_err;

  logic [15:0] mem [256];
  logic        use_mem = 1'b0;
  logic [15:0] rdata_drv = '0;

  typedef enum {S_ACC, S_PC, S_MAR, S_IR, S_FLAGS, S_BUSY, S_ERR, S_WE, S_WDATA} sig_e;
  typedef struct {
    int          due;
    sig_e        sig;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  cpu_datapath #(.DW(16), .OPW(8), .AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl      (ctrl),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .ir_out    (ir_out),
    .alu_flags (alu_flags),
    .acc_out   (acc_out),
    .pc_out    (pc_out),
    .busy      (busy),
    .ctl_err   (ctl_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = use_mem ? mem[mem_addr] : rdata_drv;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  function automatic logic [31:0] cb(input int n);
    return 32'd1 << n;
  endfunction

  function automatic logic [15:0] observe(input sig_e s);
    case (s)
      S_ACC:   return acc_out;
      S_PC:    return {8'h00, pc_out};
      S_MAR:   return {8'h00, mem_addr};
      S_IR:    return {8'h00, ir_out};
      S_FLAGS: return {12'h000, alu_flags};
      S_BUSY:  return {15'h0, busy};
      S_ERR:   return {15'h0, ctl_err};
      S_WE:    return {15'h0, mem_we};
      default: return mem_wdata;
    endcase
  endfunction

  // Monitor: every expectation due by this edge is compared 1ns after it
  always @(posedge clk) begin
    exp_t e;
    logic [15:0] got;
    cyc = cyc + 1;
    #1;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      got = observe(e.sig);
      tests_run++;
      if (got !== e.exp) begin
        tests_failed++;
        $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", e.name, got, e.exp, cyc);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] c, input logic [15:0] rd);
    @(negedge clk);
    ctrl = c;
    rdata_drv = rd;
  endtask

  task automatic step(input logic [31:0] c);
    applyStimulus(c, 16'h0000);
  endtask

  task automatic checkOutput(input sig_e s, input logic [15:0] v, input string n);
    exp_t e;
    e.due = cyc + 1;
    e.sig = s;
    e.exp = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic setMbr(input logic [15:0] v);
    applyStimulus(cb(C_MBR_LD_MEM), v);
  endtask

  task automatic setBr(input logic [15:0] v);
    setMbr(v);
    step(cb(C_BR_LD));
  endtask

  task automatic setAcc(input logic [15:0] v);
    setMbr(v);
    step(cb(C_BR_LD) | cb(C_ACC_CLR));
    step(cb(C_ACC_ADD));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    ctrl = '0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput(S_ACC, 16'h0000, "rst_acc");
    checkOutput(S_PC, 16'h0000, "rst_pc");
    checkOutput(S_MAR, 16'h0000, "rst_mar");
    checkOutput(S_IR, 16'h0000, "rst_ir");
    checkOutput(S_FLAGS, 16'h0000, "rst_flags");
    checkOutput(S_BUSY, 16'h0000, "rst_busy");
    checkOutput(S_ERR, 16'h0000, "rst_err");
    checkOutput(S_WDATA, 16'h0000, "rst_mbr");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0205;
    mem[5] = 16'h1234;
    doReset();

    // Fetch and LOAD through the memory model
    use_mem = 1'b1;
    step(cb(C_MAR_LD_PC));
    checkOutput(S_MAR, 16'h0000, "fetch_mar_pc");
    step(cb(C_MBR_LD_MEM) | cb(C_PC_INC));
    checkOutput(S_WDATA, 16'h0205, "fetch_mbr");
    checkOutput(S_PC, 16'h0001, "fetch_pc");
    step(cb(C_IR_LD));
    checkOutput(S_IR, 16'h0002, "fetch_ir");
    step(cb(C_MAR_LD_MBR));
    checkOutput(S_MAR, 16'h0005, "load_mar");
    step(cb(C_MBR_LD_MEM));
    checkOutput(S_WDATA, 16'h1234, "load_mbr");
    step(cb(C_BR_LD) | cb(C_ACC_CLR));
    checkOutput(S_ACC, 16'h0000, "load_clr");
    checkOutput(S_FLAGS, 16'h0008, "load_clr_flags");
    step(cb(C_ACC_ADD));
    checkOutput(S_ACC, 16'h1234, "load_acc");
    checkOutput(S_FLAGS, 16'h0000, "load_flags");
    checkOutput(S_PC, 16'h0001, "load_pc_hold");
    use_mem = 1'b0;

    // ADD overflow, SUB to zero
    setAcc(16'h7FFF);
    setBr(16'h0001);
    step(cb(C_ACC_ADD));
    checkOutput(S_ACC, 16'h8000, "add_acc");
    checkOutput(S_FLAGS, 16'h0003, "add_flags");
    setBr(16'h8000);
    step(cb(C_ACC_SUB));
    checkOutput(S_ACC, 16'h0000, "sub_acc");
    checkOutput(S_FLAGS, 16'h0008, "sub_flags");

    // Shifts, multiply and logic ops
    setAcc(16'h00F0);
    setBr(16'h0004);
    step(cb(C_ACC_SHL));
    checkOutput(S_ACC, 16'h0F00, "shl_acc");
    checkOutput(S_FLAGS, 16'h0000, "shl_flags");
    setAcc(16'h00F0);
    setBr(16'h0004);
    step(cb(C_ACC_SHR));
    checkOutput(S_ACC, 16'h000F, "shr_acc");
    setAcc(16'h00F0);
    setBr(16'h0005);
    step(cb(C_ACC_SHR));
    checkOutput(S_ACC, 16'h0007, "shr5_acc");
    checkOutput(S_FLAGS, 16'h0004, "shr5_cf");
    setAcc(16'h00F0);
    setBr(16'h0010);
    step(cb(C_ACC_SHL));
    checkOutput(S_ACC, 16'h0000, "shl_big_acc");
    checkOutput(S_FLAGS, 16'h0008, "shl_big_zf");
    setBr(16'h00FF);
    step(cb(C_ACC_NOT));
    checkOutput(S_ACC, 16'hFF00, "not_acc");
    checkOutput(S_FLAGS, 16'h0001, "not_sf");
    setAcc(16'h0100);
    setBr(16'h0100);
    step(cb(C_ACC_MUL));
    checkOutput(S_ACC, 16'h0000, "mul_acc");
    checkOutput(S_FLAGS, 16'h000E, "mul_flags");
    setAcc(16'hF0F0);
    setBr(16'hFF00);
    step(cb(C_ACC_AND));
    checkOutput(S_ACC, 16'hF000, "and_acc");
    step(cb(C_ACC_OR));
    checkOutput(S_ACC, 16'hFF00, "or_acc");

    // Divide 100/7 with a blocked ALU op and memory write mid-run
    doReset();
    setAcc(16'd100);
    setBr(16'd7);
    step(cb(C_ACC_DIV));
    checkOutput(S_BUSY, 16'h0001, "div_busy_start");
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) begin
        step(cb(C_ACC_ADD) | cb(C_MEM_WE));
        checkOutput(S_WE, 16'h0000, "div_we_blocked");
        checkOutput(S_ERR, 16'h0001, "div_busy_err");
        checkOutput(S_ACC, 16'd100, "div_acc_hold");
      end else begin
        step('0);
      end
      checkOutput(S_BUSY, 16'h0001, "div_busy_run");
    end
    step('0);
    checkOutput(S_ACC, 16'd14, "div_quotient");
    checkOutput(S_BUSY, 16'h0000, "div_busy_end");
    checkOutput(S_FLAGS, 16'h0000, "div_flags");

    // Divide by zero
    doReset();
    setAcc(16'd5);
    setBr(16'h0000);
    step(cb(C_ACC_DIV));
    checkOutput(S_BUSY, 16'h0001, "div0_busy");
    step('0);
    checkOutput(S_ACC, 16'hFFFF, "div0_acc");
    checkOutput(S_BUSY, 16'h0000, "div0_busy_end");
    checkOutput(S_FLAGS, 16'h0003, "div0_flags");

    // Reset in the middle of a divide
    setAcc(16'd100);
    setBr(16'd7);
    step(cb(C_ACC_DIV));
    for (int k = 1; k <= 4; k++) step('0);
    @(negedge clk);
    rst = 1'b1;
    ctrl = '0;
    checkOutput(S_ACC, 16'h0000, "divrst_acc");
    checkOutput(S_BUSY, 16'h0000, "divrst_busy");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 17; k++) step('0);
    checkOutput(S_ACC, 16'h0000, "divrst_acc_stays");
    checkOutput(S_BUSY, 16'h0000, "divrst_busy_stays");

    // Store path, then conflicting control words
    doReset();
    setAcc(16'hBEEF);
    setMbr(16'h0009);
    step(cb(C_MAR_LD_MBR));
    step(cb(C_MBR_LD_ACC));
    checkOutput(S_WDATA, 16'hBEEF, "st_mbr");
    step(cb(C_MEM_WE));
    checkOutput(S_WE, 16'h0001, "st_we");
    checkOutput(S_MAR, 16'h0009, "st_addr");
    checkOutput(S_WDATA, 16'hBEEF, "st_wdata");
    checkOutput(S_ERR, 16'h0000, "st_no_err");
    step(cb(C_ACC_ADD) | cb(C_ACC_SUB));
    checkOutput(S_ACC, 16'h7DDE, "cf_add_wins");
    checkOutput(S_FLAGS, 16'h0006, "cf_add_flags");
    checkOutput(S_ERR, 16'h0001, "cf_alu_err");
    setMbr(16'h0042);
    step(cb(C_PC_INC) | cb(C_PC_LD_MBR));
    checkOutput(S_PC, 16'h0042, "cf_pc_ld");
    setMbr(16'h0011);
    step(cb(C_MAR_LD_MBR) | cb(C_MAR_LD_PC));
    checkOutput(S_MAR, 16'h0042, "cf_mar_pc");
    applyStimulus(cb(C_MBR_LD_MEM) | cb(C_MBR_LD_ACC), 16'h1357);
    checkOutput(S_WDATA, 16'h1357, "cf_mbr_mem");

    // PC wrap and simultaneous MBR/BR loads
    doReset();
    setMbr(16'h00FF);
    step(cb(C_PC_LD_MBR));
    checkOutput(S_PC, 16'h00FF, "wrap_pc_ff");
    step(cb(C_PC_INC));
    checkOutput(S_PC, 16'h0000, "wrap_pc_0");
    setMbr(16'hAAAA);
    applyStimulus(cb(C_MBR_LD_MEM) | cb(C_BR_LD), 16'h5555);
    checkOutput(S_WDATA, 16'h5555, "pri_mbr_new");
    step(cb(C_ACC_CLR));
    step(cb(C_ACC_ADD));
    checkOutput(S_ACC, 16'hAAAA, "pri_br_old");
    checkOutput(S_FLAGS, 16'h0001, "pri_flags");
    checkOutput(S_ERR, 16'h0000, "pri_no_err");

    step('0);
    step('0);
    @(negedge clk);
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
Register-transfer datapath that executes the 32-bit control word issued each cycle by the microprogrammed control unit. Holds PC, MAR, MBR, IR, BR and ACC, drives the single-port main memory, and returns the opcode (IR) and the ALU flags that the CU uses for dispatch and conditional jumps. Multiply is single-cycle. Divide is a 16-cycle iterative sub-unit that raises busy while it runs.

Parameters:
DW, 16, data/word width (MBR, BR, ACC, memory word)
OPW, 8, opcode width; IR = MBR[DW-1:DW-OPW]
AW, 8, address width; must equal DW-OPW; MAR/PC source = MBR[AW-1:0]

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
ctrl  in  32  CU control word; bit n = Cn; bits 0-2 and 22-31 ignored
mem_rdata  in  DW  memory read data, valid combinationally for mem_addr
mem_addr  out  AW  = MAR
mem_rd  out  1  = ctrl[3]
mem_we  out  1  = ctrl[11] & ~busy
mem_wdata  out  DW  = MBR
ir_out  out  OPW  IR register, feeds CU IR_in
alu_flags  out  4  {ZF,CF,OF,SF}, registered
acc_out  out  DW  ACC (debug/observe)
pc_out  out  AW  PC (debug/observe)
busy  out  1  divider running
ctl_err  out  1  sticky: conflicting/illegal control word seen

Behaviour:
- Reset (async, rst=1): PC, MAR, MBR, IR, BR, ACC, alu_flags all 0; busy=0; ctl_err=0; divider idle.
- Every transfer samples pre-edge register values. Example: C3 and C7 in the same cycle gives BR = old MBR, MBR = mem_rdata.
- Transfers: C3 MBR<=mem_rdata; C4 IR<=MBR[DW-1:DW-OPW]; C5 MAR<=MBR[AW-1:0]; C6 PC<=PC+1 (wraps 255->0); C7 BR<=MBR; C10 MAR<=PC; C12 MBR<=ACC; C14 PC<=MBR[AW-1:0].
- Same-target conflicts, each sets ctl_err:
  - C3 and C12: C3 wins.
  - C5 and C10: C10 wins.
  - C6 and C14: C14 wins.
- ALU group C8,C9,C13,C15..C21 writes ACC.
  - More than one bit set: lowest index wins; ctl_err=1.
  - C8 ACC=0.
  - C9 ACC+BR, C13 ACC-BR: DW-bit wrap; CF = carry out (add) or borrow (sub); OF = signed overflow.
  - C15: ACC = low DW bits of unsigned ACC*BR; CF=OF=1 if the high half is nonzero.
  - C17/C18: logical shift by BR[3:0]; if BR[DW-1:4]!=0, result 0; CF = last bit shifted out (0 if amount 0).
  - C19 ACC&BR; C20 ACC|BR; C21 ~BR.
  - ZF=(result==0), SF=result[DW-1]. CF/OF=0 for ops that do not define them.
  - Flags update only on ALU-group ops; they hold otherwise.
- Divide (C16, unsigned):
  - Cycle T: latch dividend=ACC, divisor=BR; busy=1 from T+1.
  - 16 restoring iterations.
  - At edge T+16: ACC<=quotient, flags update (CF=0, OF=0), busy deasserts the following cycle.
  - BR==0: no iteration; at edge T+1 ACC<=all ones, OF=1, ZF=0, SF=1; busy pulses one cycle.
  - While busy: ALU-group bits and C11 are ignored and set ctl_err. Non-ACC transfers still execute.
  - C16 while busy is ignored (ctl_err).
- Reset mid-divide: aborts immediately; ACC=0; busy=0.

Decomposition:
- Shared package cpu_pkg:
  - control-bit index constants C_MBR_LD_MEM=3 … C_ACC_NOT=21
  - flag index constants FLAG_SF=0, FLAG_OF=1, FLAG_CF=2, FLAG_ZF=3
  - opcode constants (LOAD=8'h02, ADD=8'h03, JMPGEZ=8'h05, HALT=8'h07, AND=8'h0A, OR=8'h0B, SHIFTR=8'h0D, SHIFTL=8'h0E), shared with the CU
- One sub-module: seq_divider (start/busy/done, dividend, divisor, quotient, div0). Everything else lives in cpu_datapath.

Test Plan:
- Fetch/LOAD:
  - Memory[0]=16'h0205, memory[5]=16'h1234.
  - Cycles C10; C3+C6; C4; C5; C3; C7|C8; C9.
  - Expect ir_out=8'h02, MAR=5, PC=1, ACC=16'h1234, ZF=0, SF=0.
- ADD/SUB flags:
  - ACC=16'h7FFF, BR=1, C9: ACC=16'h8000, OF=1, SF=1, CF=0.
  - Then BR=16'h8000, C13: ACC=0, ZF=1, CF=0.
- Divide:
  - ACC=100, BR=7, C16: busy=1 for 16 cycles, then ACC=14.
  - BR=0: ACC=16'hFFFF, OF=1, busy for 1 cycle.
  - Assert rst at divide cycle 5: ACC=0, busy=0 immediately.
- Shift/logic:
  - ACC=16'h00F0, BR=4.
  - C17: ACC=16'h0F00.
  - C18 from 16'h00F0: ACC=16'h000F.
  - BR=16'h0010, C17: ACC=0, ZF=1.
  - C21 with BR=16'h00FF: ACC=16'hFF00, SF=1.
- Store/conflicts:
  - ACC=16'hBEEF, MAR=9; C12 then C11: mem_we=1, mem_addr=9, mem_wdata=16'hBEEF.
  - C9|C13 together: ADD applied, ctl_err=1.
  - C6|C14 with MBR=16'h0042: PC=8'h42, ctl_err=1.
- Wrap/priority:
  - PC=8'hFF, C6: PC=0.
  - C3 and C7 together: BR=old MBR, MBR=mem_rdata.
